// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter: op encodings, FSM state type and default operand width.
package cmp_pkg;
    localparam logic [1:0] CMP_LT = 2'b00;
    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_LE = 2'b10;
    localparam logic [1:0] CMP_NE = 2'b11;

    localparam int CMP_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/cmp_arbiter_rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr, wrapping modulo NREQ.
module rr_pick
    import cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    int          pos;
    logic [IW-1:0] pos_idx;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        // Walk offsets from farthest to nearest so the nearest valid requester is kept.
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            pos_idx = IW'(pos);
            if (req_valid[pos_idx]) begin
                any = 1'b1;
                idx = pos_idx;
            end
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbitrated comparator, one operation in flight.
// Define CMP_ARB_SIGNED_EN to honour req_sgn (two's complement compare); default build is unsigned only.
//
// state   | meaning
// IDLE    | waiting for any req_valid; grant and capture operands in the same cycle
// EXEC    | one cycle: evaluate compare on captured operands into rsp_result
// RESP    | hold rsp_valid/rsp_id/rsp_result until rsp_ready
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = CMP_WIDTH_DEFAULT,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    input  logic [NREQ-1:0]       req_sgn,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [WIDTH-1:0]      rsp_result
);
    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [1:0]       cap_op;
    logic [NREQ-1:0]  pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [IW-1:0]    next_ptr;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             cmp_res;
`ifdef CMP_ARB_SIGNED_EN
    logic             cap_sgn;
`else
    logic             sgn_unused;
    assign sgn_unused = ^req_sgn;
`endif

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    // The grant strobe is combinational so the requester sees it in the cycle it is chosen.
    assign req_ready = (rst_n && state == ST_IDLE) ? pick_grant : '0;
    assign next_ptr  = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
`ifdef CMP_ARB_SIGNED_EN
        if (cap_sgn) cmp_lt = $signed(cap_a) < $signed(cap_b);
        else         cmp_lt = cap_a < cap_b;
`else
        cmp_lt = cap_a < cap_b;
`endif
        cmp_eq = (cap_a == cap_b);
        case (cap_op)
            CMP_LT:  cmp_res = cmp_lt;
            CMP_EQ:  cmp_res = cmp_eq;
            CMP_LE:  cmp_res = cmp_lt | cmp_eq;
            default: cmp_res = ~cmp_eq;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= CMP_LT;
`ifdef CMP_ARB_SIGNED_EN
            cap_sgn    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        cap_a  <= req_a[pick_idx*WIDTH +: WIDTH];
                        cap_b  <= req_b[pick_idx*WIDTH +: WIDTH];
                        cap_op <= req_op[pick_idx*2 +: 2];
`ifdef CMP_ARB_SIGNED_EN
                        cap_sgn <= req_sgn[pick_idx];
`endif
                        rsp_id <= pick_idx;
                        rr_ptr <= next_ptr;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= {{(WIDTH-1){1'b0}}, cmp_res};
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_cmp_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ*2-1:0]     req_op = '0;
    logic [NREQ-1:0]       req_sgn = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_result;

    always #5 clk = ~clk;

    cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_sgn    (req_sgn),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input logic sgn);
        longint sa, sb;
        bit     use_s, r;
        use_s = 1'b0;
`ifdef CMP_ARB_SIGNED_EN
        use_s = sgn;
`endif
        if (use_s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        case (op)
            2'b00:   r = (sa <  sb);
            2'b01:   r = (sa == sb);
            2'b10:   r = (sa <= sb);
            default: r = (sa != sb);
        endcase
        return {31'b0, r};
    endfunction

    // Reference model: which requester is owed a grant, and the pending response.
    int          m_rr = 0;
    bit          m_pend = 1'b0;
    int          m_wait = 0;
    bit          m_vis = 1'b0;
    int          m_id = 0;
    logic [31:0] m_res = '0;
    int          m_win = -1;
    int          log_id[$];
    int          log_cyc[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        m_win = -1;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
        end else begin
            if (!m_pend) m_win = pick(req_valid, m_rr);
            exp_ready = (m_win >= 0) ? NREQ'(1 << m_win) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, m_vis);
            if (m_vis) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_res);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    log_id.push_back(i);
                    log_cyc.push_back(cyc);
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_rr = 0; m_pend = 0; m_wait = 0; m_vis = 0;
        end else begin
            if (m_vis && rsp_ready) begin
                m_vis = 0;
                m_pend = 0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_vis = 1;
            end
            if (m_win >= 0) begin
                m_pend = 1;
                m_wait = 1;
                m_id   = m_win;
                m_res  = ref_cmp(req_a[m_win*WIDTH +: WIDTH], req_b[m_win*WIDTH +: WIDTH],
                                 req_op[m_win*2 +: 2], req_sgn[m_win]);
                m_rr   = (m_win + 1) % NREQ;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int r, output int gc);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready[r]) break;
        end
        chk("grant_seen", req_ready[r], 1);
        gc = cyc;
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic sgn, input logic [31:0] exp, input bit flip);
        int gc;
        req_a[2*WIDTH +: WIDTH] = a;
        req_b[2*WIDTH +: WIDTH] = b;
        req_op[5:4] = op;
        req_sgn[2]  = sgn;
        req_valid   = 4'b0100;
        rsp_ready   = 1'b1;
        wait_grant(2, gc);
        @(posedge clk);
        #1;
        req_valid = '0;
        if (flip) req_a[2*WIDTH +: WIDTH] = ~a;
        wait_rsp();
        chk("one_latency", cyc - gc, 2);
        chk("one_id", rsp_id, 2);
        chk("one_result", rsp_result, exp);
        step();
    endtask

    initial begin
        int gc;
        int n;
        logic [31:0] sgn_exp;
`ifdef CMP_ARB_SIGNED_EN
        sgn_exp = 32'd1;
`else
        sgn_exp = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Reset while an operation is in EXEC: it must vanish and rr_ptr return to 0.
        req_a[1*WIDTH +: WIDTH] = 32'd3;
        req_b[1*WIDTH +: WIDTH] = 32'd9;
        req_valid = 4'b0010;
        wait_grant(1, gc);
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("midexec_rsp_valid", rsp_valid, 0);
        chk("midexec_req_ready", req_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        log_id.delete();
        log_cyc.delete();

        // Fairness with all requesters asserted.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 32'(i);
            req_b[i*WIDTH +: WIDTH] = 32'd2;
        end
        rsp_ready = 1'b1;
        repeat (14) @(negedge clk);
        chk("fair_count", log_id.size() >= 5, 1);
        n = (log_id.size() < 5) ? log_id.size() : 5;
        for (int i = 0; i < n; i++) chk("fair_id", log_id[i], i % NREQ);
        for (int i = 1; i < n; i++) chk("fair_gap", log_cyc[i] - log_cyc[i-1], 3);
        step();
        req_valid = '0;
        repeat (4) step();

        // Backpressure: response held five cycles, no new grant until accepted.
        req_a[31:0] = 32'd10;
        req_b[31:0] = 32'd20;
        req_op[1:0] = 2'b00;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b0;
        wait_grant(0, gc);
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        wait_rsp();
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_result", rsp_result, 1);
            chk("bp_no_grant", req_ready, 0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_valid", rsp_valid, 1);
        chk("bp_accept_no_grant", req_ready, 0);
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        repeat (4) step();

        run_one(32'd0, 32'd1, 2'b00, 1'b0, 32'd1, 1'b0);
        run_one(32'd1, 32'd1, 2'b00, 1'b0, 32'd0, 1'b0);
        run_one(32'd1, 32'd1, 2'b10, 1'b0, 32'd1, 1'b0);
        run_one(32'd7, 32'd7, 2'b01, 1'b0, 32'd1, 1'b0);
        run_one(32'd7, 32'd8, 2'b11, 1'b0, 32'd1, 1'b0);
        run_one(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b1, sgn_exp, 1'b0);
        run_one(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 32'd0, 1'b0);
        run_one(32'd5, 32'd7, 2'b00, 1'b0, 32'd1, 1'b1);

        // Randomized traffic; the reference model checks every cycle.
        for (int t = 0; t < 3000; t++) begin
            req_valid = NREQ'($urandom);
            req_sgn   = NREQ'($urandom);
            req_op    = (NREQ*2)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] b;
                b = (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
                req_b[i*WIDTH +: WIDTH] = b;
                case ($urandom_range(0, 3))
                    0:       req_a[i*WIDTH +: WIDTH] = $urandom;
                    1:       req_a[i*WIDTH +: WIDTH] = 32'($urandom_range(0, 3));
                    2:       req_a[i*WIDTH +: WIDTH] = 32'h7FFF_FFFE + 32'($urandom_range(0, 3));
                    default: req_a[i*WIDTH +: WIDTH] = b;
                endcase
            end
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
